// File: rtl/z80_arb_pkg.sv
// Shared types for the Z80 bus arbiters: FSM state encoding and size limits.
package z80_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        GRANT,
        GAP,
        REL
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: picks the first set bit of req at or
// after ptr, wrapping at NREQ. Returns the winner as one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        int cand;
        onehot = '0;
        idx    = '0;
        cand   = 0;
        // Walk offsets from farthest to nearest so the nearest match is written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[cand]) begin
                onehot       = '0;
                onehot[cand] = 1'b1;
                idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the Z80 external bus between the CPU (via BUSREQ_L/BUSACK_L) and NREQ
// round-robin requesters. Optional per-grant cycle limit: Z80_ARB_TENURE_LIMIT_EN.
module z80_bus_arbiter
    import z80_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_B2B = 2,
    parameter int TENURE  = 64
) (
    input  logic                    clk,
    input  logic                    rst_L,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         gnt,
    output logic                    BUSREQ_L,
    input  logic                    BUSACK_L,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
`ifdef Z80_ARB_TENURE_LIMIT_EN
    ,
    output logic                    revoked
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_B2B + 1);

    if (NREQ < 2 || NREQ > NREQ_MAX || MAX_B2B < 1 || TENURE < 1) begin : g_bad_cfg
        $error("z80_bus_arbiter: unsupported parameter set");
    end

    arb_state_t      state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [IW-1:0]   owner_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n;
    logic [BW-1:0]   b2b_cnt, b2b_n;
    logic            busreq_n;
    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            tenure_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

`ifdef Z80_ARB_TENURE_LIMIT_EN
    localparam int TW = $clog2(TENURE + 1);
    logic [TW-1:0] ten_cnt, ten_n;
    logic          revoked_n;

    // Counter is held at zero outside GRANT, so every new grant starts from zero.
    assign tenure_hit = (int'(ten_cnt) == TENURE - 1);

    always_comb begin
        ten_n     = (state == GRANT) ? ten_cnt + 1'b1 : '0;
        revoked_n = (state == GRANT) && tenure_hit && !done[owner] && req[owner];
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ten_cnt <= '0;
            revoked <= 1'b0;
        end else begin
            ten_cnt <= ten_n;
            revoked <= revoked_n;
        end
    end
`else
    assign tenure_hit = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        b2b_n    = b2b_cnt;
        busreq_n = BUSREQ_L;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n  = ACQ;
                    busreq_n = 1'b0;
                end
            end
            ACQ: begin
                // Once the CPU has yielded, the bus is handed back cleanly even if nobody wants it.
                if (!BUSACK_L) begin
                    if (|req) begin
                        state_n = GRANT;
                        gnt_n   = pick_oh;
                        owner_n = pick_idx;
                    end else begin
                        state_n  = REL;
                        busreq_n = 1'b1;
                        b2b_n    = '0;
                    end
                end
            end
            GRANT: begin
                if (done[owner] || !req[owner] || tenure_hit) begin
                    state_n  = GAP;
                    gnt_n    = '0;
                    owner_n  = '0;
                    rr_ptr_n = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    if (int'(b2b_cnt) < MAX_B2B) begin
                        b2b_n = b2b_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (|req && int'(b2b_cnt) < MAX_B2B) begin
                    state_n = GRANT;
                    gnt_n   = pick_oh;
                    owner_n = pick_idx;
                end else begin
                    state_n  = REL;
                    busreq_n = 1'b1;
                    b2b_n    = '0;
                end
            end
            REL: begin
                if (BUSACK_L) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state    <= IDLE;
            BUSREQ_L <= 1'b1;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            b2b_cnt  <= '0;
        end else begin
            state    <= state_n;
            BUSREQ_L <= busreq_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            busy     <= ~busreq_n | ~BUSACK_L;
            rr_ptr   <= rr_ptr_n;
            b2b_cnt  <= b2b_n;
        end
    end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: two instances (MAX_B2B=2 and 1) behind a simple Z80
// BUSREQ/BUSACK responder; grant order is checked against a queue of expected winners.
module tb_z80_bus_arbiter;

    localparam int N       = 4;
    localparam int ACK_DLY = 3;

    logic         clk = 1'b0;
    logic         rst_L;
    logic [N-1:0] req [2];
    logic [N-1:0] done [2];
    logic [N-1:0] gnt [2];
    logic         busreq_l [2];
    logic         busack_l [2];
    logic         busy [2];
    logic [1:0]   owner [2];
`ifdef Z80_ARB_TENURE_LIMIT_EN
    logic         revoked [2];
`endif

    int errors = 0;
    int checks = 0;
    int exp_q0[$];
    int exp_q1[$];

    always #5 clk = ~clk;

    z80_bus_arbiter #(
        .NREQ(N), .MAX_B2B(2)
`ifdef Z80_ARB_TENURE_LIMIT_EN
        , .TENURE(8)
`endif
    ) u_dut0 (
        .clk(clk), .rst_L(rst_L), .req(req[0]), .done(done[0]), .gnt(gnt[0]),
        .BUSREQ_L(busreq_l[0]), .BUSACK_L(busack_l[0]), .busy(busy[0]), .owner(owner[0])
`ifdef Z80_ARB_TENURE_LIMIT_EN
        , .revoked(revoked[0])
`endif
    );

    z80_bus_arbiter #(
        .NREQ(N), .MAX_B2B(1)
`ifdef Z80_ARB_TENURE_LIMIT_EN
        , .TENURE(8)
`endif
    ) u_dut1 (
        .clk(clk), .rst_L(rst_L), .req(req[1]), .done(done[1]), .gnt(gnt[1]),
        .BUSREQ_L(busreq_l[1]), .BUSACK_L(busack_l[1]), .busy(busy[1]), .owner(owner[1])
`ifdef Z80_ARB_TENURE_LIMIT_EN
        , .revoked(revoked[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_L   = 1'b0;
        req[0]  = '0;
        req[1]  = '0;
        done[0] = '0;
        done[1] = '0;
        repeat (2) @(negedge clk);
        rst_L = 1'b1;
    endtask

    // Waits for a grant, holds it, then pulses done (optionally dropping req with it).
    task automatic grant_cycle(input int k, input int hold, input bit drop,
                               output int zeros, output int rel_seen, output int cpu_cyc,
                               output logic [N-1:0] g);
        zeros    = 0;
        rel_seen = 0;
        cpu_cyc  = 0;
        while (gnt[k] == '0 && zeros < 200) begin
            step();
            zeros++;
            if (busreq_l[k]) rel_seen = 1;
            if (busreq_l[k] && busack_l[k]) cpu_cyc++;
        end
        g = gnt[k];
        chk(k == 0 ? "gnt_wait0" : "gnt_wait1", 32'(g != '0), 1);
        if (g != '0) begin
            repeat (hold) step();
            chk("gnt_hold", gnt[k], g);
            chk("busy_grant", busy[k], 1);
            @(negedge clk);
            done[k] = g;
            if (drop) req[k] = req[k] & ~g;
            step();
            done[k] = '0;
            chk("gnt_drop", gnt[k], 0);
        end
    endtask

    // Z80 core model: acknowledges ACK_DLY negedges after BUSREQ_L falls, releases at once.
    initial begin
        int lowcnt [2];
        lowcnt[0]   = 0;
        lowcnt[1]   = 0;
        busack_l[0] = 1'b1;
        busack_l[1] = 1'b1;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_L !== 1'b1 || busreq_l[k] !== 1'b0) begin
                    lowcnt[k]   = 0;
                    busack_l[k] = 1'b1;
                end else begin
                    lowcnt[k]++;
                    if (lowcnt[k] >= ACK_DLY) busack_l[k] = 1'b0;
                end
            end
        end
    end

    // Scoreboard: every rising grant must match the next expected winner.
    initial begin
        logic [N-1:0] prev_g [2];
        int e;
        prev_g[0] = '0;
        prev_g[1] = '0;
        forever begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (rst_L === 1'b1 && gnt[k] != '0 && prev_g[k] == '0) begin
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        chk("sb_unexpected", gnt[k], 0);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk(k == 0 ? "sb_gnt0" : "sb_gnt1", gnt[k], 32'(1) << e);
                        chk("sb_owner", owner[k], e);
                    end
                end
                prev_g[k] = (rst_L === 1'b1) ? gnt[k] : '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int zeros, rel, cpu, ia, ir, anyg, hi, rv;
        logic [N-1:0] g;
        logic [5:0] st;

        // Reset, then idle with no requests.
        rst_L   = 1'b0;
        req[0]  = '0;
        req[1]  = '0;
        done[0] = '0;
        done[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busreq", busreq_l[0], 1);
        chk("rst_gnt", gnt[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_owner", owner[0], 0);
        rst_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            st = {busreq_l[0], gnt[0], busy[0]};
            chk("idle_state", st, 6'b100000);
        end

        // Single request: grant arrives on the edge that first sees BUSACK_L low.
        do_reset();
        exp_q0.push_back(1);
        req[0] = 4'b0010;
        grant_cycle(0, 2, 1'b1, zeros, rel, cpu, g);
        chk("single_lat", zeros, ACK_DLY + 1);
        chk("single_gnt", g, 4'b0010);
        chk("gap_busreq_low", busreq_l[0], 0);
        step();
        chk("rel_busreq_high", busreq_l[0], 1);
        repeat (3) step();
        chk("idle_busy", busy[0], 0);
        chk("idle_busreq", busreq_l[0], 1);

        // Round-robin with req=1011 held and MAX_B2B=2: 0, 1, release, 3, 0.
        do_reset();
        exp_q0.push_back(0);
        exp_q0.push_back(1);
        exp_q0.push_back(3);
        exp_q0.push_back(0);
        req[0] = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            grant_cycle(0, 2, 1'b0, zeros, rel, cpu, g);
            if (i == 1) chk("rr_gap", zeros, 1);
            if (i == 2) begin
                chk("rr_rel", rel, 1);
                chk("rr_cpu_win", 32'(cpu >= 1), 1);
            end
            if (i == 3) chk("rr_gap2", zeros, 1);
        end

        // Back-to-back cap of one: BUSREQ_L must rise between every grant.
        do_reset();
        exp_q1.push_back(0);
        exp_q1.push_back(1);
        exp_q1.push_back(0);
        req[1] = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            grant_cycle(1, 1, 1'b0, zeros, rel, cpu, g);
            if (i > 0) begin
                chk("cap_rel", rel, 1);
                chk("cap_cpu_win", 32'(cpu >= 1), 1);
            end
        end

        // Abort in ACQ: request vanishes before the CPU acknowledges.
        do_reset();
        req[0] = 4'b0100;
        step();
        chk("abort_acq", busreq_l[0], 0);
        @(negedge clk);
        req[0] = '0;
        ia   = -1;
        ir   = -1;
        anyg = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ia < 0 && busack_l[0] == 1'b0) ia = i;
            if (ir < 0 && busreq_l[0] == 1'b1) ir = i;
            if (gnt[0] != '0) anyg = 1;
        end
        chk("abort_ack_seen", 32'(ia >= 0), 1);
        chk("abort_rel_edge", ir, ia);
        chk("abort_no_gnt", anyg, 0);
        chk("abort_busy", busy[0], 0);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        exp_q0.push_back(0);
        req[0] = 4'b0001;
        zeros  = 0;
        while (gnt[0] == '0 && zeros < 50) begin
            step();
            zeros++;
        end
        chk("arst_granted", gnt[0], 4'b0001);
        #2;
        rst_L = 1'b0;
        #1;
        chk("arst_gnt", gnt[0], 0);
        chk("arst_busreq", busreq_l[0], 1);
        chk("arst_owner", owner[0], 0);
        @(negedge clk);
        req[0] = '0;
        rst_L  = 1'b1;

`ifdef Z80_ARB_TENURE_LIMIT_EN
        // Tenure limit of 8: grant without done lasts 8 cycles, then the next requester.
        do_reset();
        exp_q0.push_back(0);
        exp_q0.push_back(1);
        req[0] = 4'b0011;
        zeros  = 0;
        while (gnt[0] == '0 && zeros < 50) begin
            step();
            zeros++;
        end
        hi = 0;
        rv = 0;
        while (gnt[0] != '0 && hi < 40) begin
            if (revoked[0]) rv = 1;
            hi++;
            step();
        end
        chk("ten_len", hi, 8);
        chk("ten_no_early", rv, 0);
        chk("ten_revoked", revoked[0], 1);
        step();
        chk("ten_pulse_end", revoked[0], 0);
        chk("ten_next", gnt[0], 4'b0010);
        @(negedge clk);
        req[0] = '0;
        repeat (6) step();
`endif

        repeat (3) step();
        chk("sb_left0", exp_q0.size(), 0);
        chk("sb_left1", exp_q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z80_bus_arbiter.md
Name: z80_bus_arbiter

Overview:
- Shares the Z80 external bus (addr_bus, data_bus, MREQ_L/IORQ_L/RD_L/WR_L) between the CPU and N DMA-style requesters.
- Talks to the CPU only through BUSREQ_L/BUSACK_L.
- Grants one requester at a time, round-robin.
- Returns the bus to the CPU after a bounded number of back-to-back tenures, so the CPU is never starved.
- Sits at top level beside the z80 core, between the core and the memory/IO requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_B2B, 2, maximum consecutive requester tenures before BUSREQ_L is released back to the CPU (≥1).
- TENURE, 64, cycle limit per grant; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_L  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester bus request; level; held until done.
- done  input  NREQ  per-requester one-cycle release pulse; valid only while granted.
- gnt  output  NREQ  one-hot grant; requester may drive the bus only while its bit is high.
- BUSREQ_L  output  1  bus request to the z80 core.
- BUSACK_L  input  1  bus acknowledge from the z80 core; synchronous to clk.
- busy  output  1  high whenever BUSREQ_L is low or BUSACK_L is low.
- owner  output  $clog2(NREQ)  index of the current grantee; 0 when gnt==0.

Behaviour:
- One clock; reset is asynchronous and active-low: rst_L low forces state IDLE, BUSREQ_L=1, gnt=0, owner=0, busy=0, rr_ptr=0, b2b_cnt=0, tenure counter=0. All outputs are registered.
- IDLE:
  - If |req, go to ACQ and drive BUSREQ_L=0 next cycle.
- ACQ:
  - Hold BUSREQ_L=0 until BUSACK_L==0.
  - The cycle BUSACK_L is sampled low, select the winner: first set bit of req at or after rst_ptr (rotating).
  - Next cycle: gnt=onehot(winner), owner=winner, state GRANT.
  - If req drops to 0 in ACQ before BUSACK_L: stay in ACQ until BUSACK_L, then go to REL. The CPU bus cycle is already yielded; it must be returned cleanly.
- GRANT:
  - gnt holds until done[owner]. done bits for non-owners are ignored.
  - On done[owner]: gnt=0 next cycle, rr_ptr=owner+1 (mod NREQ), b2b_cnt++.
  - Then go to GAP for exactly one cycle with gnt=0 (bus turnaround).
  - If req[owner] drops without done, treat it as done in the same cycle.
- GAP:
  - If |req and b2b_cnt<MAX_B2B: arbitrate as in ACQ and go to GRANT. BUSREQ_L stays low.
  - Else: go to REL.
- REL:
  - BUSREQ_L=1, b2b_cnt=0.
  - Wait until BUSACK_L==1, then go to IDLE.
  - A new req seen in REL is not serviced until IDLE. The CPU gets at least one full cycle of bus ownership.
- Simultaneous events: req and done in the same cycle resolve as done-first. The same requester can win again only via round-robin order.
- BUSACK_L falling while in IDLE or REL-complete is a protocol error. It is ignored; gnt stays 0.
- Reset mid-grant drops gnt and releases BUSREQ_L asynchronously.
- Counters:
  - b2b_cnt is $clog2(MAX_B2B+1) bits and saturates.
  - rr_ptr wraps at NREQ, not at a power of two.

Optional Feature:
- Macro Z80_ARB_TENURE_LIMIT_EN.
- Defined:
  - A $clog2(TENURE+1)-bit counter clears on grant and increments in GRANT.
  - When it reaches TENURE, the grant is revoked: gnt=0 next cycle, exactly as if done[owner] had pulsed.
  - Output revoked pulses for one cycle.
- Not defined: no counter and no revoked port. A grant lasts until done or req drop.

Decomposition:
- Shared package z80_arb_pkg holds:
  - arb_state_t enum {IDLE, ACQ, GRANT, GAP, REL};
  - NREQ_MAX=8.
- One natural sub-module: rr_pick, a combinational rotating priority encoder. It takes req, ptr and returns onehot and index. It is reusable by the IO arbiter.
- The FSM and counters stay in the top.

Test Plan:
- Reset then idle: rst_L low 2 cycles, req=0 for 10 cycles -> BUSREQ_L=1, gnt=0, busy=0 throughout.
- Single request: req=4'b0010; core drops BUSACK_L 3 cycles after BUSREQ_L -> gnt=4'b0010 one cycle after BUSACK_L low. done pulse -> gnt=0 next cycle, BUSREQ_L=1 after GAP. BUSACK_L high -> IDLE.
- Round-robin: req=4'b1011 held, MAX_B2B=2 -> grants 0 then 1 with a 1-cycle gap. REL happens, the CPU gets ≥1 cycle, then grants 3 then 0.
- Back-to-back cap: MAX_B2B=1, req=4'b0011 -> BUSREQ_L deasserts between every grant.
- Abort in ACQ: req=4'b0100 drops before BUSACK_L low -> BUSREQ_L released one cycle after BUSACK_L low, gnt never asserted.
- Tenure limit (Z80_ARB_TENURE_LIMIT_EN, TENURE=8): grant with no done -> gnt drops on cycle 9 and revoked pulses once. The next requester is granted after GAP.
